// File: rtl/icache_direct_mapped_if.sv
// rtl/icache_direct_mapped_if.sv - CPU fetch and memory refill channels of the instruction cache
// The cache takes the slave view; the CPU/memory environment takes the master view.
interface icache_direct_mapped_if;
  logic        from_cpu_inst_req_valid;
  logic [31:0] from_cpu_inst_req_addr;
  logic        to_cpu_inst_req_ready;
  logic        to_cpu_cache_rsp_valid;
  logic [31:0] to_cpu_cache_rsp_data;
  logic        from_cpu_cache_rsp_ready;
  logic        to_mem_rd_req_valid;
  logic [31:0] to_mem_rd_req_addr;
  logic        from_mem_rd_req_ready;
  logic        from_mem_rd_rsp_valid;
  logic [31:0] from_mem_rd_rsp_data;
  logic        from_mem_rd_rsp_last;
  logic        to_mem_rd_rsp_ready;

  modport slave (
    input  from_cpu_inst_req_valid, from_cpu_inst_req_addr, from_cpu_cache_rsp_ready,
    input  from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_data,
    input  from_mem_rd_rsp_last,
    output to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
    output to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
  );

  modport master (
    output from_cpu_inst_req_valid, from_cpu_inst_req_addr, from_cpu_cache_rsp_ready,
    output from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_data,
    output from_mem_rd_rsp_last,
    input  to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
    input  to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache with line refill
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counter outputs.
module icache_direct_mapped #(
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  icache_direct_mapped_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);
  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 32 - IDX - OFF - 2;
  localparam logic [OFF:0] LINE_CNT = (OFF+1)'(LINE_WORDS);

  typedef enum logic [4:0] {
    S_WAIT    = 5'b00001,
    S_TAG_RD  = 5'b00010,
    S_MEM_REQ = 5'b00100,
    S_RECV    = 5'b01000,
    S_RESP    = 5'b10000
  } state_e;

  state_e             state_q;
  logic [31:2]        addr_q;
  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [31:0]        data_q [SETS*LINE_WORDS];
  logic [OFF:0]       cnt_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic               mem_req_valid_q;
  logic [31:0]        mem_req_addr_q;
  logic               mem_rsp_ready_q;

  logic [TAG_W-1:0]   tag;
  logic [IDX-1:0]     idx;
  logic [OFF-1:0]     off;
  logic               hit;
  logic               beat_fire;
  logic               beat_in_line;
  logic               unused_addr_bits;

  assign tag          = addr_q[31 -: TAG_W];
  assign idx          = addr_q[OFF+2 +: IDX];
  assign off          = addr_q[2 +: OFF];
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign beat_fire    = (state_q == S_RECV) && bus.from_mem_rd_rsp_valid;
  assign beat_in_line = cnt_q < LINE_CNT;
  assign unused_addr_bits = ^bus.from_cpu_inst_req_addr[1:0];

  assign bus.to_cpu_inst_req_ready  = req_ready_q;
  assign bus.to_cpu_cache_rsp_valid = rsp_valid_q;
  assign bus.to_cpu_cache_rsp_data  = rsp_data_q;
  assign bus.to_mem_rd_req_valid    = mem_req_valid_q;
  assign bus.to_mem_rd_req_addr     = mem_req_addr_q;
  assign bus.to_mem_rd_rsp_ready    = mem_rsp_ready_q;

  // Tag and data arrays carry no reset; only valid_q decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (beat_fire && beat_in_line) begin
      data_q[{idx, cnt_q[OFF-1:0]}] <= bus.from_mem_rd_rsp_data;
    end
    if (beat_fire && bus.from_mem_rd_rsp_last) begin
      tag_q[idx] <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_WAIT;
      addr_q          <= '0;
      valid_q         <= '0;
      cnt_q           <= '0;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_rsp_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (bus.from_cpu_inst_req_valid) begin
            addr_q      <= bus.from_cpu_inst_req_addr[31:2];
            req_ready_q <= 1'b0;
            state_q     <= S_TAG_RD;
          end
        end
        S_TAG_RD: begin
          if (hit) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= data_q[{idx, off}];
            state_q     <= S_RESP;
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= {tag, idx, {(OFF+2){1'b0}}};
            state_q         <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (bus.from_mem_rd_req_ready) begin
            mem_req_valid_q <= 1'b0;
            mem_rsp_ready_q <= 1'b1;
            cnt_q           <= '0;
            state_q         <= S_RECV;
          end
        end
        S_RECV: begin
          if (bus.from_mem_rd_rsp_valid) begin
            // The requested word is captured as it streams past, so RESP needs no extra read.
            if (beat_in_line) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q[OFF-1:0] == off) begin
                rsp_data_q <= bus.from_mem_rd_rsp_data;
              end
            end
            if (bus.from_mem_rd_rsp_last) begin
              valid_q[idx]    <= 1'b1;
              mem_rsp_ready_q <= 1'b0;
              rsp_valid_q     <= 1'b1;
              state_q         <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bus.from_cpu_cache_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_TAG_RD) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - directed vector bench for the direct-mapped instruction cache
// Vector table for full fetches plus a hand-written reset-during-refill sequence.
module tb_icache_direct_mapped;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_direct_mapped_if bus_if();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_direct_mapped #(.SETS(8), .LINE_WORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    bit          exp_miss;
    logic [31:0] exp_line;
    int          mem_stall;
    int          rsp_stall;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
    if (line == 32'h0) return 32'hA0 + 32'(i);
    return 32'hB000_0000 + line + 32'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input logic [31:0] line, input int n, input bit with_last);
    int accepted = 0;
    for (int i = 0; i < n; i++) begin
      bus_if.from_mem_rd_rsp_valid = 1'b1;
      bus_if.from_mem_rd_rsp_data  = mem_word(line, i);
      bus_if.from_mem_rd_rsp_last  = with_last && (i == n - 1);
      if (bus_if.to_mem_rd_rsp_ready) accepted++;
      step();
    end
    bus_if.from_mem_rd_rsp_valid = 1'b0;
    bus_if.from_mem_rd_rsp_last  = 1'b0;
    check("beats_accepted", 32'(accepted), 32'(n));
  endtask

  task automatic issue_req(input logic [31:0] addr);
    check("req_ready_idle", 32'(bus_if.to_cpu_inst_req_ready), 32'd1);
    bus_if.from_cpu_inst_req_valid = 1'b1;
    bus_if.from_cpu_inst_req_addr  = addr;
    step();
    bus_if.from_cpu_inst_req_valid = 1'b0;
    bus_if.from_cpu_inst_req_addr  = 32'h0;
    check("req_ready_busy", 32'(bus_if.to_cpu_inst_req_ready), 32'd0);
    step();
  endtask

  task automatic fetch(input vec_t v);
    issue_req(v.addr);
    if (v.exp_miss) begin
      check("mem_req_valid", 32'(bus_if.to_mem_rd_req_valid), 32'd1);
      check("mem_req_addr", bus_if.to_mem_rd_req_addr, v.exp_line);
      check("rsp_valid_early", 32'(bus_if.to_cpu_cache_rsp_valid), 32'd0);
      for (int i = 0; i < v.mem_stall; i++) begin
        step();
        check("mem_req_hold_valid", 32'(bus_if.to_mem_rd_req_valid), 32'd1);
        check("mem_req_hold_addr", bus_if.to_mem_rd_req_addr, v.exp_line);
        check("req_ready_stall", 32'(bus_if.to_cpu_inst_req_ready), 32'd0);
      end
      bus_if.from_mem_rd_req_ready = 1'b1;
      step();
      bus_if.from_mem_rd_req_ready = 1'b0;
      check("mem_req_drop", 32'(bus_if.to_mem_rd_req_valid), 32'd0);
      send_beats(v.exp_line, 8, 1'b1);
    end else begin
      check("mem_req_on_hit", 32'(bus_if.to_mem_rd_req_valid), 32'd0);
    end
    check("rsp_valid_latency", 32'(bus_if.to_cpu_cache_rsp_valid), 32'd1);
    for (int i = 0; i < v.rsp_stall; i++) begin
      check("rsp_hold_valid", 32'(bus_if.to_cpu_cache_rsp_valid), 32'd1);
      check("rsp_hold_data", bus_if.to_cpu_cache_rsp_data, v.exp_data);
      check("req_ready_rsp_stall", 32'(bus_if.to_cpu_inst_req_ready), 32'd0);
      step();
    end
    check("rsp_data", bus_if.to_cpu_cache_rsp_data, v.exp_data);
    bus_if.from_cpu_cache_rsp_ready = 1'b1;
    step();
    bus_if.from_cpu_cache_rsp_ready = 1'b0;
    check("rsp_done", 32'(bus_if.to_cpu_cache_rsp_valid), 32'd0);
    check("req_ready_back", 32'(bus_if.to_cpu_inst_req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(bus_if.to_cpu_inst_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus_if.to_cpu_cache_rsp_valid), 32'd0);
    check("rst_rsp_data", bus_if.to_cpu_cache_rsp_data, 32'h0);
    check("rst_mem_req_valid", 32'(bus_if.to_mem_rd_req_valid), 32'd0);
    check("rst_mem_req_addr", bus_if.to_mem_rd_req_addr, 32'h0);
    check("rst_mem_rsp_ready", 32'(bus_if.to_mem_rd_rsp_ready), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h0000_00A4, 1'b1, 32'h0000_0000, 0, 0};
    vecs[1] = '{32'h0000_001C, 32'h0000_00A7, 1'b0, 32'h0000_0000, 0, 0};
    vecs[2] = '{32'h0000_0100, 32'hB000_0100, 1'b1, 32'h0000_0100, 5, 3};
    vecs[3] = '{32'h0000_0000, 32'h0000_00A0, 1'b1, 32'h0000_0000, 0, 0};
    vecs[4] = '{32'h0000_0024, 32'hB000_0021, 1'b1, 32'h0000_0020, 0, 0};
    vecs[5] = '{32'h0000_003C, 32'hB000_0027, 1'b0, 32'h0000_0000, 0, 0};
    vecs[6] = '{32'h0000_0000, 32'h0000_00A0, 1'b1, 32'h0000_0000, 0, 0};

    rst = 1'b1;
    bus_if.from_cpu_inst_req_valid  = 1'b0;
    bus_if.from_cpu_inst_req_addr   = 32'h0;
    bus_if.from_cpu_cache_rsp_ready = 1'b0;
    bus_if.from_mem_rd_req_ready    = 1'b0;
    bus_if.from_mem_rd_rsp_valid    = 1'b0;
    bus_if.from_mem_rd_rsp_data     = 32'h0;
    bus_if.from_mem_rd_rsp_last     = 1'b0;
    step();
    step();
    check_reset_outputs();
    rst = 1'b0;

    // A stray beat while idle must not be accepted.
    bus_if.from_mem_rd_rsp_valid = 1'b1;
    bus_if.from_mem_rd_rsp_data  = 32'hDEAD_BEEF;
    step();
    check("stray_beat_ready", 32'(bus_if.to_mem_rd_rsp_ready), 32'd0);
    bus_if.from_mem_rd_rsp_valid = 1'b0;

    for (int i = 0; i < 4; i++) fetch(vecs[i]);

    // Reset after 3 of 8 refill beats for line 0x20.
    issue_req(32'h0000_0024);
    check("rr_mem_req_valid", 32'(bus_if.to_mem_rd_req_valid), 32'd1);
    check("rr_mem_req_addr", bus_if.to_mem_rd_req_addr, 32'h0000_0020);
    bus_if.from_mem_rd_req_ready = 1'b1;
    step();
    bus_if.from_mem_rd_req_ready = 1'b0;
    send_beats(32'h0000_0020, 3, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt_before_rst", hit_cnt, 32'd1);
    check("miss_cnt_before_rst", miss_cnt, 32'd4);
`endif
    rst = 1'b1;
    step();
    check_reset_outputs();
    rst = 1'b0;

    for (int i = 4; i < 7; i++) fetch(vecs[i]);
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt_final", hit_cnt, 32'd1);
    check("miss_cnt_final", miss_cnt, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
